// File: rtl/decode_stage_if.sv
// Decode stage handshake/bus bundle: upstream instruction feed plus registered decode outputs.
interface decode_stage_if #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5
);
  logic               in_valid_i;
  logic               in_ready_o;
  logic [31:0]        inst_i;
  logic [XLEN-1:0]    pc_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [4:0]         rs1_o, rs2_o, rd_o;
  logic [XLEN-1:0]    imm_o, pc_o;
  logic [ALUOP_W-1:0] aluop_o;
  logic [2:0]         brfunct_o;
  logic               alusrc_o, pc_src_o, lui_o, jal_o, jalr_o, branch_o;
  logic               mem_to_reg_o, mem_wen_o, mem_ren_o, reg_wen_o, illegal_o;

  modport slave (
    input  in_valid_i, inst_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, rs1_o, rs2_o, rd_o, imm_o, pc_o, aluop_o, brfunct_o,
           alusrc_o, pc_src_o, lui_o, jal_o, jalr_o, branch_o,
           mem_to_reg_o, mem_wen_o, mem_ren_o, reg_wen_o, illegal_o
  );

  modport master (
    output in_valid_i, inst_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, rs1_o, rs2_o, rd_o, imm_o, pc_o, aluop_o, brfunct_o,
           alusrc_o, pc_src_o, lui_o, jal_o, jalr_o, branch_o,
           mem_to_reg_o, mem_wen_o, mem_ren_o, reg_wen_o, illegal_o
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage with output register + one skid entry (EMPTY/FULL/SKID).
// Optional M-extension decode enabled by macro DECODE_STAGE_MULDIV_EN.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  decode_stage_if.slave bus
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("decode_stage: XLEN must be 32");
  end

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [ALUOP_W-1:0] aluop;
    logic [2:0]         brfunct;
    logic               alusrc;
    logic               pc_src;
    logic               lui;
    logic               jal;
    logic               jalr;
    logic               branch;
    logic               mem_to_reg;
    logic               mem_wen;
    logic               mem_ren;
    logic               reg_wen;
    logic               illegal;
  } dec_t;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [ALUOP_W-1:0] A_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] A_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] A_AND  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] A_OR   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] A_XOR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] A_SRA  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] A_SRL  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] A_SLL  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] A_SLT  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] A_SLTU = ALUOP_W'(10);
`ifdef DECODE_STAGE_MULDIV_EN
  localparam logic [ALUOP_W-1:0] A_MUL  = ALUOP_W'(11);
`endif

  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    sx = {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  logic [31:0] inst;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_sb, imm_u, imm_uj;
  dec_t        dec;

  assign inst   = bus.inst_i;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_sb = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_uj = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec       = '0;
    dec.pc    = bus.pc_i;
    dec.rs1   = inst[19:15];
    dec.rs2   = inst[24:20];
    dec.rd    = inst[11:7];
    dec.aluop = A_ADD;
    case (opcode)
      OPC_OP: begin
        dec.reg_wen = 1'b1;
        case (funct7)
          7'b0000000:
            case (funct3)
              3'b000:  dec.aluop = A_ADD;
              3'b001:  dec.aluop = A_SLL;
              3'b010:  dec.aluop = A_SLT;
              3'b011:  dec.aluop = A_SLTU;
              3'b100:  dec.aluop = A_XOR;
              3'b101:  dec.aluop = A_SRL;
              3'b110:  dec.aluop = A_OR;
              default: dec.aluop = A_AND;
            endcase
          7'b0100000:
            case (funct3)
              3'b000:  dec.aluop = A_SUB;
              3'b101:  dec.aluop = A_SRA;
              default: dec.illegal = 1'b1;
            endcase
`ifdef DECODE_STAGE_MULDIV_EN
          7'b0000001: dec.aluop = A_MUL + ALUOP_W'(funct3);
`else
          7'b0000001: dec.illegal = 1'b1;
`endif
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.imm     = sx(imm_i);
        dec.alusrc  = 1'b1;
        dec.reg_wen = 1'b1;
        case (funct3)
          3'b000:  dec.aluop = A_ADD;
          3'b001: begin
            dec.aluop = A_SLL;
            if (funct7 != 7'b0000000) dec.illegal = 1'b1;
          end
          3'b010:  dec.aluop = A_SLT;
          3'b011:  dec.aluop = A_SLTU;
          3'b100:  dec.aluop = A_XOR;
          3'b101: begin
            if (funct7 == 7'b0000000)      dec.aluop = A_SRL;
            else if (funct7 == 7'b0100000) dec.aluop = A_SRA;
            else                           dec.illegal = 1'b1;
          end
          3'b110:  dec.aluop = A_OR;
          default: dec.aluop = A_AND;
        endcase
      end
      OPC_LOAD: begin
        dec.imm        = sx(imm_i);
        dec.alusrc     = 1'b1;
        dec.mem_ren    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_wen    = 1'b1;
      end
      OPC_STORE: begin
        dec.imm     = sx(imm_s);
        dec.alusrc  = 1'b1;
        dec.mem_wen = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm     = sx(imm_sb);
        dec.aluop   = A_SUB;
        dec.branch  = 1'b1;
        dec.brfunct = funct3;
        // funct3 010/011 are unassigned branch encodings
        if (funct3[2:1] == 2'b01) dec.illegal = 1'b1;
      end
      OPC_JAL: begin
        dec.imm     = sx(imm_uj);
        dec.jal     = 1'b1;
        dec.reg_wen = 1'b1;
      end
      OPC_JALR: begin
        dec.imm     = sx(imm_i);
        dec.alusrc  = 1'b1;
        dec.jalr    = 1'b1;
        dec.reg_wen = 1'b1;
      end
      OPC_LUI: begin
        dec.imm     = sx(imm_u);
        dec.alusrc  = 1'b1;
        dec.lui     = 1'b1;
        dec.reg_wen = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm     = sx(imm_u);
        dec.alusrc  = 1'b1;
        dec.pc_src  = 1'b1;
        dec.reg_wen = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // illegal instructions must not cause any architectural side effect
    if (dec.illegal) begin
      dec.reg_wen = 1'b0;
      dec.mem_wen = 1'b0;
      dec.mem_ren = 1'b0;
      dec.branch  = 1'b0;
      dec.jal     = 1'b0;
      dec.jalr    = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_wen = 1'b0;
  end

  state_t state_q, state_d;
  dec_t   oreg, skid;
  logic   accept, drain;
  logic   ld_oreg_in, ld_oreg_skid, ld_skid;

  // handshake qualifiers depend only on registered state
  assign accept = bus.in_valid_i  && (state_q != S_SKID);
  assign drain  = bus.out_ready_i && (state_q != S_EMPTY);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = S_EMPTY;
    else
      case (state_q)
        S_EMPTY: if (accept) state_d = S_FULL;
        S_FULL: begin
          if (accept && !drain)      state_d = S_SKID;
          else if (!accept && drain) state_d = S_EMPTY;
        end
        S_SKID:  if (drain) state_d = S_FULL;
        default: state_d = S_EMPTY;
      endcase
  end

  always_comb begin
    bus.in_ready_o  = (state_q != S_SKID);
    bus.out_valid_o = (state_q != S_EMPTY);
    ld_oreg_in      = 1'b0;
    ld_oreg_skid    = 1'b0;
    ld_skid         = 1'b0;
    if (!flush_i)
      case (state_q)
        S_EMPTY: ld_oreg_in = accept;
        S_FULL: begin
          ld_oreg_in = accept && drain;
          ld_skid    = accept && !drain;
        end
        S_SKID:  ld_oreg_skid = drain;
        default: ;
      endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oreg <= '0;
      skid <= '0;
    end else begin
      if (ld_oreg_in)        oreg <= dec;
      else if (ld_oreg_skid) oreg <= skid;
      if (ld_skid)           skid <= dec;
    end
  end

  assign bus.pc_o         = oreg.pc;
  assign bus.imm_o        = oreg.imm;
  assign bus.rs1_o        = oreg.rs1;
  assign bus.rs2_o        = oreg.rs2;
  assign bus.rd_o         = oreg.rd;
  assign bus.aluop_o      = oreg.aluop;
  assign bus.brfunct_o    = oreg.brfunct;
  assign bus.alusrc_o     = oreg.alusrc;
  assign bus.pc_src_o     = oreg.pc_src;
  assign bus.lui_o        = oreg.lui;
  assign bus.jal_o        = oreg.jal;
  assign bus.jalr_o       = oreg.jalr;
  assign bus.branch_o     = oreg.branch;
  assign bus.mem_to_reg_o = oreg.mem_to_reg;
  assign bus.mem_wen_o    = oreg.mem_wen;
  assign bus.mem_ren_o    = oreg.mem_ren;
  assign bus.reg_wen_o    = oreg.reg_wen;
  assign bus.illegal_o    = oreg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors, queued expectations, negedge monitor.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage dut (.clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(bus));

  // flags: {alusrc, pc_src, lui, jal, jalr, branch, mem_to_reg, mem_wen, mem_ren, reg_wen, illegal}
  localparam logic [10:0] F_ALUSRC = 11'h400, F_PCSRC = 11'h200, F_LUI = 11'h100, F_JAL  = 11'h080;
  localparam logic [10:0] F_JALR   = 11'h040, F_BR    = 11'h020, F_M2R = 11'h010, F_MWEN = 11'h008;
  localparam logic [10:0] F_MREN   = 11'h004, F_RWEN  = 11'h002, F_ILL = 11'h001;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0]  aluop;
    logic [2:0]  brf;
    logic [10:0] flags;
  } pkt_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  aluop;
    logic [2:0]  brf;
    logic [10:0] flags;
  } vec_t;

  pkt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vt [0:16];

  function automatic pkt_t mk(input vec_t v, input logic [31:0] pc);
    pkt_t r;
    r.pc = pc; r.rs1 = v.inst[19:15]; r.rs2 = v.inst[24:20]; r.rd = v.inst[11:7];
    r.imm = v.imm; r.aluop = v.aluop; r.brf = v.brf; r.flags = v.flags;
    return r;
  endfunction

  function automatic pkt_t act();
    pkt_t r;
    r.pc = bus.pc_o; r.rs1 = bus.rs1_o; r.rs2 = bus.rs2_o; r.rd = bus.rd_o;
    r.imm = bus.imm_o; r.aluop = bus.aluop_o; r.brf = bus.brfunct_o;
    r.flags = {bus.alusrc_o, bus.pc_src_o, bus.lui_o, bus.jal_o, bus.jalr_o, bus.branch_o,
               bus.mem_to_reg_o, bus.mem_wen_o, bus.mem_ren_o, bus.reg_wen_o, bus.illegal_o};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chk_pkt(input string nm, input pkt_t a, input pkt_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got pc=%h rd=%0d rs1=%0d rs2=%0d imm=%h aluop=%0d brf=%0d flags=%h expected pc=%h rd=%0d rs1=%0d rs2=%0d imm=%h aluop=%0d brf=%0d flags=%h",
               nm, a.pc, a.rd, a.rs1, a.rs2, a.imm, a.aluop, a.brf, a.flags,
               e.pc, e.rd, e.rs1, e.rs2, e.imm, e.aluop, e.brf, e.flags);
    end
  endtask

  // monitor: pop on each real output transfer; check hold while stalled
  pkt_t snap;
  logic snap_v = 1'b0;
  always @(negedge clk) begin
    if (snap_v && bus.out_valid_o) chk_pkt("hold_stable", act(), snap);
    snap_v = 1'b0;
    if (rst_n && !flush && bus.out_valid_o) begin
      if (bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got pc=%h expected none", bus.pc_o);
        end else chk_pkt("decode_out", act(), exp_q.pop_front());
      end else begin
        snap   = act();
        snap_v = 1'b1;
      end
    end
  end

  task automatic issue(input vec_t v, input logic [31:0] pc, input bit push);
    bus.in_valid_i = 1'b1;
    bus.inst_i     = v.inst;
    bus.pc_i       = pc;
    if (push) exp_q.push_back(mk(v, pc));
  endtask

  task automatic wait_accept(input string nm);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready_o && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready_o) begin
      checks++; errors++;
      $display("FAIL %s_accept_timeout: got in_ready 0 expected 1", nm);
    end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic send(input vec_t v, input logic [31:0] pc);
    issue(v, pc, 1'b1);
    wait_accept("send");
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    vt = '{
      '{32'hFFF00293, 32'hFFFFFFFF, 5'd0,  3'd0, F_ALUSRC | F_RWEN},          // ADDI x5,x0,-1
      '{32'h002081B3, 32'h00000000, 5'd0,  3'd0, F_RWEN},                     // ADD x3,x1,x2
      '{32'h40208233, 32'h00000000, 5'd1,  3'd0, F_RWEN},                     // SUB x4,x1,x2
      '{32'h0020F463, 32'h00000008, 5'd1,  3'd7, F_BR},                       // BGEU x1,x2,+8
      '{32'h0000007F, 32'h00000000, 5'd0,  3'd0, F_ILL},                      // unknown opcode
`ifdef DECODE_STAGE_MULDIV_EN
      '{32'h023100B3, 32'h00000000, 5'd11, 3'd0, F_RWEN},                     // MUL x1,x2,x3
`else
      '{32'h023100B3, 32'h00000000, 5'd0,  3'd0, F_ILL},                      // MUL x1,x2,x3
`endif
      '{32'h00208033, 32'h00000000, 5'd0,  3'd0, 11'h000},                    // ADD x0,x1,x2
      '{32'h123453B7, 32'h12345000, 5'd0,  3'd0, F_ALUSRC | F_LUI | F_RWEN},  // LUI x7
      '{32'hFFFFF417, 32'hFFFFF000, 5'd0,  3'd0, F_ALUSRC | F_PCSRC | F_RWEN},// AUIPC x8
      '{32'hFFC12303, 32'hFFFFFFFC, 5'd0,  3'd0, F_ALUSRC | F_M2R | F_MREN | F_RWEN}, // LW
      '{32'h00512623, 32'h0000000C, 5'd0,  3'd0, F_ALUSRC | F_MWEN},          // SW x5,12(x2)
      '{32'h010000EF, 32'h00000010, 5'd0,  3'd0, F_JAL | F_RWEN},             // JAL x1,+16
      '{32'h00008067, 32'h00000000, 5'd0,  3'd0, F_ALUSRC | F_JALR},          // JALR x0,0(x1)
      '{32'h0020A463, 32'h00000008, 5'd1,  3'd2, F_ILL},                      // branch funct3 010
      '{32'h0050B093, 32'h00000005, 5'd10, 3'd0, F_ALUSRC | F_RWEN},          // SLTIU x1,x1,5
      '{32'h4020D1B3, 32'h00000000, 5'd5,  3'd0, F_RWEN},                     // SRA x3,x1,x2
      '{32'h4020F1B3, 32'h00000000, 5'd0,  3'd0, F_ILL}                       // bad funct7
    };
    bus.in_valid_i  = 1'b0;
    bus.inst_i      = '0;
    bus.pc_i        = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_in_ready", bus.in_ready_o, 1);
    chk("rst_reg_wen", bus.reg_wen_o, 0);
    chk("rst_imm", bus.imm_o, 0);
    rst_n = 1'b1;

    // single-cycle latency from EMPTY
    bus.out_ready_i = 1'b1;
    send(vt[0], 32'h100);
    chk("latency_out_valid", bus.out_valid_o, 1);
    @(posedge clk); #1;
    chk("drained_out_valid", bus.out_valid_o, 0);

    for (int i = 1; i < 17; i++) send(vt[i], 32'h100 + 32'(4 * i));
    wait_drain();

    // fill OREG + SKID with downstream stalled, third stays upstream
    bus.out_ready_i = 1'b0;
    send(vt[1], 32'h200);
    send(vt[2], 32'h204);
    issue(vt[3], 32'h208, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("skid_in_ready", bus.in_ready_o, 0);
      chk("skid_out_valid", bus.out_valid_o, 1);
    end
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    wait_accept("third");
    wait_drain();

    // flush while SKID with simultaneous input and drain
    bus.out_ready_i = 1'b0;
    send(vt[7], 32'h300);
    send(vt[8], 32'h304);
    chk("pre_flush_in_ready", bus.in_ready_o, 0);
    issue(vt[9], 32'h308, 1'b0);
    bus.out_ready_i = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("flush_out_valid", bus.out_valid_o, 0);
    chk("flush_in_ready", bus.in_ready_o, 1);
    @(posedge clk); #1;
    chk("flush_still_empty", bus.out_valid_o, 0);

    // reset while FULL
    bus.out_ready_i = 1'b0;
    send(vt[10], 32'h400);
    chk("pre_rst_out_valid", bus.out_valid_o, 1);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", bus.out_valid_o, 0);
    chk("midrst_in_ready", bus.in_ready_o, 1);

    bus.out_ready_i = 1'b1;
    send(vt[6], 32'h500);
    send(vt[15], 32'h504);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
